// File: rtl/rx_ccsk_sym_buf.sv
// Ping-pong frame buffer between the CCSK despreader and the RS decoder.
// Low-quality symbols are flagged as erasures and counted per frame.
`timescale 1ns/1ps
module rx_ccsk_sym_buf #(
  parameter int         FRAME_LEN = 31,
  parameter logic [2:0] QUAL_TH   = 3'd4
) (
  input  logic        logic_clk_in,
  input  logic        logic_rst_n_in,
  input  logic        frame_start_in,
  input  logic        sym_wr_in,
  input  logic [7:0]  sym_data_in,
  output logic        rs_valid_out,
  input  logic        rs_ready_in,
  output logic [4:0]  rs_sym_out,
  output logic        rs_erase_out,
  output logic        rs_sop_out,
  output logic        rs_eop_out,
  output logic [5:0]  rs_erase_cnt_out,
  output logic        overflow_out,
  output logic        partial_drop_out,
  output logic [15:0] frame_cnt_out,
  output logic [63:0] debug_signal
);

  localparam int         IW   = $clog2(FRAME_LEN);
  localparam logic [5:0] LAST = 6'(FRAME_LEN - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  logic [5:0] bank0_mem [FRAME_LEN];
  logic [5:0] bank1_mem [FRAME_LEN];

  state_t          state_q, state_d;
  logic [5:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]      bank_full_q, bank_full_d;
  logic [1:0][5:0] ecnt_q, ecnt_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic            overflow_q, overflow_d, partial_drop_q, partial_drop_d;
  logic            rs_valid_q, rs_valid_d, rs_erase_q, rs_erase_d;
  logic            rs_sop_q, rs_sop_d, rs_eop_q, rs_eop_d;
  logic [4:0]      rs_sym_q, rs_sym_d;
  logic [5:0]      rs_ecnt_q, rs_ecnt_d;

  logic       sym_erase, mem_we;
  logic [5:0] wr_idx;
  logic [1:0] set_full, clr_full;
  logic       ld, ld_bank, out_clear;
  logic [5:0] ld_idx, rd_entry;

  // Write side: a frame_start is applied before a coincident symbol write.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    wr_bank_d      = wr_bank_q;
    ecnt_d         = ecnt_q;
    set_full       = 2'b00;
    overflow_d     = 1'b0;
    partial_drop_d = 1'b0;
    mem_we         = 1'b0;
    wr_idx         = wr_ptr_q;
    sym_erase      = (sym_data_in[7:5] < QUAL_TH);
    if (frame_start_in && !bank_full_q[wr_bank_q]) begin
      wr_idx            = 6'd0;
      wr_ptr_d          = 6'd0;
      ecnt_d[wr_bank_q] = 6'd0;
      partial_drop_d    = (wr_ptr_q != 6'd0);
    end
    if (sym_wr_in) begin
      if (bank_full_q[wr_bank_q]) begin
        overflow_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        if (wr_idx == 6'd0)
          ecnt_d[wr_bank_q] = {5'd0, sym_erase};
        else if (sym_erase && ecnt_q[wr_bank_q] != 6'd63)
          ecnt_d[wr_bank_q] = ecnt_q[wr_bank_q] + 6'd1;
        if (wr_idx == LAST) begin
          set_full[wr_bank_q] = 1'b1;
          wr_ptr_d            = 6'd0;
          wr_bank_d           = ~wr_bank_q;
        end else begin
          wr_ptr_d = wr_idx + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge logic_clk_in) begin
    if (mem_we && !wr_bank_q) bank0_mem[wr_idx[IW-1:0]] <= {sym_erase, sym_data_in[4:0]};
    if (mem_we &&  wr_bank_q) bank1_mem[wr_idx[IW-1:0]] <= {sym_erase, sym_data_in[4:0]};
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    clr_full    = 2'b00;
    ld          = 1'b0;
    ld_bank     = rd_bank_q;
    ld_idx      = rd_ptr_q;
    out_clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          state_d  = STREAM;
          rd_ptr_d = 6'd0;
          ld       = 1'b1;
          ld_idx   = 6'd0;
        end
      end
      STREAM: begin
        if (rs_valid_q && rs_ready_in) begin
          if (rd_ptr_q != LAST) begin
            rd_ptr_d = rd_ptr_q + 6'd1;
            ld       = 1'b1;
            ld_idx   = rd_ptr_q + 6'd1;
          end else begin
            clr_full[rd_bank_q] = 1'b1;
            rd_bank_d           = ~rd_bank_q;
            rd_ptr_d            = 6'd0;
            frame_cnt_d         = frame_cnt_q + 16'd1;
            // The other bank may already be waiting: start it without a gap.
            if (bank_full_q[~rd_bank_q]) begin
              ld      = 1'b1;
              ld_bank = ~rd_bank_q;
              ld_idx  = 6'd0;
            end else begin
              state_d   = IDLE;
              out_clear = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_entry = ld_bank ? bank1_mem[ld_idx[IW-1:0]] : bank0_mem[ld_idx[IW-1:0]];

  always_comb begin
    rs_valid_d = rs_valid_q;
    rs_sym_d   = rs_sym_q;
    rs_erase_d = rs_erase_q;
    rs_sop_d   = rs_sop_q;
    rs_eop_d   = rs_eop_q;
    rs_ecnt_d  = rs_ecnt_q;
    if (ld) begin
      rs_valid_d = 1'b1;
      rs_sym_d   = rd_entry[4:0];
      rs_erase_d = rd_entry[5];
      rs_sop_d   = (ld_idx == 6'd0);
      rs_eop_d   = (ld_idx == LAST);
      rs_ecnt_d  = (ld_idx == LAST) ? ecnt_q[ld_bank] : 6'd0;
    end else if (out_clear) begin
      rs_valid_d = 1'b0;
      rs_sym_d   = 5'd0;
      rs_erase_d = 1'b0;
      rs_sop_d   = 1'b0;
      rs_eop_d   = 1'b0;
      rs_ecnt_d  = 6'd0;
    end
  end

  assign bank_full_d = (bank_full_q | set_full) & ~clr_full;

  always_ff @(posedge logic_clk_in or negedge logic_rst_n_in) begin
    if (!logic_rst_n_in) begin
      state_q        <= IDLE;
      wr_ptr_q       <= 6'd0;
      rd_ptr_q       <= 6'd0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      bank_full_q    <= 2'b00;
      ecnt_q         <= '0;
      frame_cnt_q    <= 16'd0;
      overflow_q     <= 1'b0;
      partial_drop_q <= 1'b0;
      rs_valid_q     <= 1'b0;
      rs_sym_q       <= 5'd0;
      rs_erase_q     <= 1'b0;
      rs_sop_q       <= 1'b0;
      rs_eop_q       <= 1'b0;
      rs_ecnt_q      <= 6'd0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      bank_full_q    <= bank_full_d;
      ecnt_q         <= ecnt_d;
      frame_cnt_q    <= frame_cnt_d;
      overflow_q     <= overflow_d;
      partial_drop_q <= partial_drop_d;
      rs_valid_q     <= rs_valid_d;
      rs_sym_q       <= rs_sym_d;
      rs_erase_q     <= rs_erase_d;
      rs_sop_q       <= rs_sop_d;
      rs_eop_q       <= rs_eop_d;
      rs_ecnt_q      <= rs_ecnt_d;
    end
  end

  assign rs_valid_out     = rs_valid_q;
  assign rs_sym_out       = rs_sym_q;
  assign rs_erase_out     = rs_erase_q;
  assign rs_sop_out       = rs_sop_q;
  assign rs_eop_out       = rs_eop_q;
  assign rs_erase_cnt_out = rs_ecnt_q;
  assign overflow_out     = overflow_q;
  assign partial_drop_out = partial_drop_q;
  assign frame_cnt_out    = frame_cnt_q;
  assign debug_signal     = {47'd0, wr_ptr_q, rd_ptr_q, bank_full_q, wr_bank_q, rd_bank_q, state_q};

endmodule
